// File: rtl/mpu_uart_emu.sv
// MPU UART far-end emulator: parses FF AA addr valL valH commands from the rx byte
// stream and periodically streams 11-byte angle/temperature frames to the tx core.
module mpu_uart_emu #(
   parameter int unsigned FRAME_PERIOD = 1000000,
   parameter int unsigned CMD_TIMEOUT  = 50000,
   parameter logic [7:0]  CMD_HEAD0    = 8'hFF,
   parameter logic [7:0]  CMD_HEAD1    = 8'hAA,
   parameter logic [7:0]  FRM_HEAD     = 8'h55,
   parameter logic [7:0]  FRM_TYPE     = 8'h53
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_vld,
   output logic [7:0]  tx_data,
   output logic        tx_vld,
   input  logic        tx_ready,
   input  logic [15:0] angle_x,
   input  logic [15:0] angle_y,
   input  logic [15:0] angle_z,
   input  logic [15:0] temp,
   input  logic        err_inj,
   output logic [7:0]  cfg_addr,
   output logic [15:0] cfg_value,
   output logic        cfg_vld,
   output logic        stream_on,
   output logic [15:0] frame_cnt,
   output logic [15:0] cmd_cnt
);

   typedef enum logic [2:0] {C_H0, C_H1, C_AD, C_VL, C_VH} cmd_state_t;
   typedef enum logic [2:0] {T_IDLE, T_SNAP, T_SEND, T_HOLD, T_WAIT} tx_state_t;

   cmd_state_t  cst_q, cst_d;
   logic [31:0] tmo_q, tmo_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  vall_q, vall_d;
   logic [7:0]  cfg_addr_q, cfg_addr_d;
   logic [15:0] cfg_value_q, cfg_value_d;
   logic        cfg_vld_q, cfg_vld_d;
   logic [15:0] cmd_cnt_q, cmd_cnt_d;
   logic        stream_on_q, stream_on_d;

   logic [31:0] per_q, per_d;
   logic        pending_q, pending_d;

   tx_state_t   tst_q, tst_d;
   logic [3:0]  idx_q, idx_d;
   logic [15:0] ax_q, ax_d, ay_q, ay_d, az_q, az_d, tp_q, tp_d;
   logic        err_q, err_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [7:0]  sum_c;
   logic [7:0]  frame_byte;

   always_comb begin
      cst_d       = cst_q;
      tmo_d       = tmo_q;
      addr_d      = addr_q;
      vall_d      = vall_q;
      cfg_addr_d  = cfg_addr_q;
      cfg_value_d = cfg_value_q;
      cfg_vld_d   = 1'b0;
      cmd_cnt_d   = cmd_cnt_q;
      stream_on_d = stream_on_q;
      if (rx_vld) begin
         tmo_d = '0;
         case (cst_q)
            C_H0: if (rx_data == CMD_HEAD0) cst_d = C_H1;
            C_H1: begin
               if (rx_data == CMD_HEAD1)      cst_d = C_AD;
               else if (rx_data != CMD_HEAD0) cst_d = C_H0;
            end
            C_AD: begin
               addr_d = rx_data;
               cst_d  = C_VL;
            end
            C_VL: begin
               vall_d = rx_data;
               cst_d  = C_VH;
            end
            C_VH: begin
               cfg_addr_d  = addr_q;
               cfg_value_d = {rx_data, vall_q};
               cfg_vld_d   = 1'b1;
               cmd_cnt_d   = cmd_cnt_q + 16'd1;
               if (addr_q == 8'h01) begin
                  if ({rx_data, vall_q} == 16'h0000)      stream_on_d = 1'b0;
                  else if ({rx_data, vall_q} == 16'h0001) stream_on_d = 1'b1;
               end
               cst_d = C_H0;
            end
            default: cst_d = C_H0;
         endcase
      end else if (cst_q != C_H0) begin
         // The CMD_TIMEOUT-th consecutive idle cycle abandons the partial command.
         if (tmo_q >= CMD_TIMEOUT - 1) begin
            cst_d = C_H0;
            tmo_d = '0;
         end else begin
            tmo_d = tmo_q + 32'd1;
         end
      end else begin
         tmo_d = '0;
      end
   end

   always_comb begin
      per_d     = per_q;
      pending_d = pending_q;
      if (!stream_on_q) begin
         per_d     = '0;
         pending_d = 1'b0;
      end else begin
         if (tst_q == T_SNAP) pending_d = 1'b0;
         if (per_q == FRAME_PERIOD - 1) begin
            per_d     = '0;
            pending_d = 1'b1;
         end else begin
            per_d = per_q + 32'd1;
         end
      end
   end

   always_comb begin
      sum_c = FRM_HEAD + FRM_TYPE + ax_q[7:0] + ax_q[15:8] + ay_q[7:0] + ay_q[15:8]
            + az_q[7:0] + az_q[15:8] + tp_q[7:0] + tp_q[15:8];
      case (idx_q)
         4'd0:    frame_byte = FRM_HEAD;
         4'd1:    frame_byte = FRM_TYPE;
         4'd2:    frame_byte = ax_q[7:0];
         4'd3:    frame_byte = ax_q[15:8];
         4'd4:    frame_byte = ay_q[7:0];
         4'd5:    frame_byte = ay_q[15:8];
         4'd6:    frame_byte = az_q[7:0];
         4'd7:    frame_byte = az_q[15:8];
         4'd8:    frame_byte = tp_q[7:0];
         4'd9:    frame_byte = tp_q[15:8];
         default: frame_byte = err_q ? ~sum_c : sum_c;
      endcase
   end

   always_comb begin
      tst_d       = tst_q;
      idx_d       = idx_q;
      ax_d        = ax_q;
      ay_d        = ay_q;
      az_d        = az_q;
      tp_d        = tp_q;
      err_d       = err_q;
      frame_cnt_d = frame_cnt_q;
      tx_vld      = 1'b0;
      tx_data     = '0;
      case (tst_q)
         T_IDLE: if (pending_q) tst_d = T_SNAP;
         T_SNAP: begin
            ax_d  = angle_x;
            ay_d  = angle_y;
            az_d  = angle_z;
            tp_d  = temp;
            err_d = err_inj;
            idx_d = '0;
            tst_d = T_SEND;
         end
         T_SEND: begin
            if (tx_ready) begin
               tx_vld  = 1'b1;
               tx_data = frame_byte;
               tst_d   = T_HOLD;
            end
         end
         // tx_ready lags tx_vld by a cycle, so it is not trusted right after a launch.
         T_HOLD: tst_d = T_WAIT;
         T_WAIT: begin
            if (tx_ready) begin
               if (idx_q == 4'd10) begin
                  tst_d       = T_IDLE;
                  frame_cnt_d = frame_cnt_q + 16'd1;
               end else begin
                  idx_d = idx_q + 4'd1;
                  tst_d = T_SEND;
               end
            end
         end
         default: tst_d = T_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cst_q       <= C_H0;
         tmo_q       <= '0;
         addr_q      <= '0;
         vall_q      <= '0;
         cfg_addr_q  <= '0;
         cfg_value_q <= '0;
         cfg_vld_q   <= 1'b0;
         cmd_cnt_q   <= '0;
         stream_on_q <= 1'b1;
         per_q       <= '0;
         pending_q   <= 1'b0;
         tst_q       <= T_IDLE;
         idx_q       <= '0;
         ax_q        <= '0;
         ay_q        <= '0;
         az_q        <= '0;
         tp_q        <= '0;
         err_q       <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         cst_q       <= cst_d;
         tmo_q       <= tmo_d;
         addr_q      <= addr_d;
         vall_q      <= vall_d;
         cfg_addr_q  <= cfg_addr_d;
         cfg_value_q <= cfg_value_d;
         cfg_vld_q   <= cfg_vld_d;
         cmd_cnt_q   <= cmd_cnt_d;
         stream_on_q <= stream_on_d;
         per_q       <= per_d;
         pending_q   <= pending_d;
         tst_q       <= tst_d;
         idx_q       <= idx_d;
         ax_q        <= ax_d;
         ay_q        <= ay_d;
         az_q        <= az_d;
         tp_q        <= tp_d;
         err_q       <= err_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign cfg_addr  = cfg_addr_q;
   assign cfg_value = cfg_value_q;
   assign cfg_vld   = cfg_vld_q;
   assign stream_on = stream_on_q;
   assign frame_cnt = frame_cnt_q;
   assign cmd_cnt   = cmd_cnt_q;

endmodule

// File: tb/tb_mpu_uart_emu.sv
// Randomized bench for mpu_uart_emu: a queue-based command model and a frame
// builder predict cfg pulses and transmitted frames.
module tb_mpu_uart_emu;
   localparam int unsigned PERIOD = 100;
   localparam int unsigned CTO    = 40;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_vld = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_vld;
   logic        tx_ready = 1'b1;
   logic [15:0] angle_x = 16'h0102;
   logic [15:0] angle_y = 16'h0304;
   logic [15:0] angle_z = 16'h0506;
   logic [15:0] temp    = 16'h0708;
   logic        err_inj = 1'b0;
   logic [7:0]  cfg_addr;
   logic [15:0] cfg_value;
   logic        cfg_vld;
   logic        stream_on;
   logic [15:0] frame_cnt;
   logic [15:0] cmd_cnt;

   always #5 clk = ~clk;

   mpu_uart_emu #(.FRAME_PERIOD(PERIOD), .CMD_TIMEOUT(CTO)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_vld(rx_vld),
      .tx_data(tx_data), .tx_vld(tx_vld), .tx_ready(tx_ready),
      .angle_x(angle_x), .angle_y(angle_y), .angle_z(angle_z), .temp(temp),
      .err_inj(err_inj), .cfg_addr(cfg_addr), .cfg_value(cfg_value),
      .cfg_vld(cfg_vld), .stream_on(stream_on), .frame_cnt(frame_cnt),
      .cmd_cnt(cmd_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [7:0]  a;
      logic [15:0] v;
      logic [15:0] cnt;
      logic        so;
   } cmd_t;

   cmd_t       exp_q[$];
   logic [7:0] cand[$];
   int         model_cmds   = 0;
   logic       model_stream = 1'b1;
   int         cyc = 0;
   int         last_cyc = 0;

   always @(posedge clk) cyc++;

   // command scoreboard
   int pulses = 0;
   bit prev_cfg = 0;
   always @(negedge clk) begin
      if (!rst) begin
         pulses   = 0;
         prev_cfg = 0;
      end else begin
         if (cfg_vld) begin
            cmd_t e;
            check_eq("cfg_vld_width", prev_cfg, 0);
            pulses++;
            if (exp_q.size() == 0) begin
               check_eq("cfg_unexpected", cfg_vld, 0);
            end else begin
               e = exp_q.pop_front();
               check_eq("cfg_addr", cfg_addr, e.a);
               check_eq("cfg_value", cfg_value, e.v);
               check_eq("cmd_cnt", cmd_cnt, e.cnt);
               check_eq("stream_on", stream_on, e.so);
            end
         end
         prev_cfg = cfg_vld;
      end
   end

   // tx ready model and frame scoreboard
   int         tx_idx = 0;
   int         frames_done = 0;
   int         bytes_total = 0;
   int         busy = 0;
   int         scripted = 0;
   bit         prev_vld = 0;
   logic [7:0] exp_frame [11];
   always @(negedge clk) begin
      if (!rst) begin
         tx_idx      = 0;
         frames_done = 0;
         prev_vld    = 0;
         busy        = 0;
         tx_ready    = 1'b1;
      end else begin
         if (tx_vld) begin
            check_eq("tx_vld_width", prev_vld, 0);
            if (tx_idx == 0) begin
               logic [7:0] s;
               check_eq("frame_cnt", frame_cnt, frames_done);
               exp_frame[0] = 8'h55;
               exp_frame[1] = 8'h53;
               exp_frame[2] = angle_x[7:0];
               exp_frame[3] = angle_x[15:8];
               exp_frame[4] = angle_y[7:0];
               exp_frame[5] = angle_y[15:8];
               exp_frame[6] = angle_z[7:0];
               exp_frame[7] = angle_z[15:8];
               exp_frame[8] = temp[7:0];
               exp_frame[9] = temp[15:8];
               s = 8'h00;
               for (int i = 0; i < 10; i++) s = s + exp_frame[i];
               exp_frame[10] = err_inj ? ~s : s;
               // the snapshot for this frame is done; set up inputs for the next one
               if (scripted == 0) begin
                  err_inj = 1'b1;
               end else begin
                  angle_x = 16'($urandom);
                  angle_y = 16'($urandom);
                  angle_z = 16'($urandom);
                  temp    = 16'($urandom);
                  err_inj = ($urandom_range(0, 3) == 0);
               end
               scripted++;
            end
            check_eq($sformatf("frame_byte%0d", tx_idx), tx_data, exp_frame[tx_idx]);
            tx_idx++;
            bytes_total++;
            if (tx_idx == 11) begin
               tx_idx = 0;
               frames_done++;
            end
            busy     = (scripted <= 2) ? 10 : $urandom_range(1, 12);
            tx_ready = 1'b0;
         end else if (busy > 0) begin
            busy--;
            if (busy == 0) tx_ready = 1'b1;
         end
         prev_vld = tx_vld;
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) @(negedge clk);
      if (cyc - last_cyc - 1 >= int'(CTO)) cand.delete();
      last_cyc = cyc;
      rx_data  = b;
      rx_vld   = 1'b1;
      if (cand.size() == 0) begin
         if (b == 8'hFF) cand.push_back(b);
      end else if (cand.size() == 1) begin
         if (b == 8'hAA) cand.push_back(b);
         else if (b != 8'hFF) cand.delete();
      end else begin
         cand.push_back(b);
         if (cand.size() == 5) begin
            cmd_t e;
            model_cmds++;
            e.a = cand[2];
            e.v = {cand[4], cand[3]};
            if (e.a == 8'h01 && e.v == 16'h0000) model_stream = 1'b0;
            if (e.a == 8'h01 && e.v == 16'h0001) model_stream = 1'b1;
            e.cnt = 16'(model_cmds);
            e.so  = model_stream;
            exp_q.push_back(e);
            cand.delete();
         end
      end
      @(negedge clk);
      rx_vld = 1'b0;
   endtask

   task automatic send_cmd(input logic [7:0] a, input logic [15:0] v);
      send_byte(8'hFF, $urandom_range(0, 4));
      send_byte(8'hAA, $urandom_range(0, 4));
      send_byte(a, $urandom_range(0, 4));
      send_byte(v[7:0], $urandom_range(0, 4));
      send_byte(v[15:8], $urandom_range(0, 4));
   endtask

   task automatic checkpoint(input string tag);
      repeat (4) @(negedge clk);
      check_eq({tag, "_pulses"}, pulses, model_cmds);
      check_eq({tag, "_cmd_cnt"}, cmd_cnt, 16'(model_cmds));
      check_eq({tag, "_leftover"}, exp_q.size(), 0);
   endtask

   initial begin
      int b0, f0;
      bit seen;
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_tx_vld", tx_vld, 0);
      check_eq("rst_tx_data", tx_data, 0);
      check_eq("rst_cfg_vld", cfg_vld, 0);
      check_eq("rst_cfg_addr", cfg_addr, 0);
      check_eq("rst_cfg_value", cfg_value, 0);
      check_eq("rst_stream_on", stream_on, 1);
      check_eq("rst_frame_cnt", frame_cnt, 0);
      check_eq("rst_cmd_cnt", cmd_cnt, 0);
      @(negedge clk);
      rst = 1'b1;
      last_cyc = cyc;

      send_cmd(8'h10, 16'h1234);
      checkpoint("accept");

      send_byte(8'hFF, 1); send_byte(8'hFF, 1); send_byte(8'hAA, 0);
      send_byte(8'h20, 2); send_byte(8'h01, 0); send_byte(8'h00, 3);
      checkpoint("resync");
      send_byte(8'hFF, 1); send_byte(8'h00, 1); send_byte(8'hAA, 0);
      send_byte(8'h20, 2); send_byte(8'h01, 0); send_byte(8'h00, 3);
      checkpoint("broken_hdr");

      send_byte(8'hFF, 1); send_byte(8'hAA, 1); send_byte(8'h05, 1);
      send_byte(8'h01, CTO); send_byte(8'h00, 0);
      checkpoint("timeout");
      send_byte(8'hFF, 1); send_byte(8'hAA, 1); send_byte(8'h05, 1);
      send_byte(8'h01, CTO - 1); send_byte(8'h00, 0);
      checkpoint("timeout_edge");

      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), $urandom_range(0, 6));
         send_cmd(8'($urandom_range(2, 255)), 16'($urandom));
      end
      checkpoint("random");

      for (int i = 0; i < 2000 && frames_done < 3; i++) @(negedge clk);
      check_eq("frames_streamed", frames_done >= 3, 1);

      send_cmd(8'h01, 16'h0000);
      checkpoint("stream_off");
      check_eq("stream_on_off", stream_on, 0);
      repeat (400) @(negedge clk);
      b0 = bytes_total;
      f0 = frames_done;
      repeat (3 * PERIOD) @(negedge clk);
      check_eq("off_no_bytes", bytes_total, b0);
      check_eq("off_frame_cnt", frame_cnt, 16'(f0));

      send_cmd(8'h01, 16'h0001);
      seen = 0;
      for (int i = 0; i < int'(PERIOD) + 4 && !seen; i++) begin
         @(negedge clk);
         if (tx_vld) seen = 1;
      end
      check_eq("stream_resume", seen, 1);
      checkpoint("stream_on");

      seen = 0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk);
         if (tx_idx == 5) seen = 1;
      end
      check_eq("reach_mid_frame", seen, 1);
      rst = 1'b0;
      #1;
      check_eq("midrst_tx_vld", tx_vld, 0);
      check_eq("midrst_frame_cnt", frame_cnt, 0);
      check_eq("midrst_cmd_cnt", cmd_cnt, 0);
      check_eq("midrst_stream_on", stream_on, 1);
      check_eq("midrst_cfg_addr", cfg_addr, 0);
      cand.delete();
      exp_q.delete();
      model_cmds   = 0;
      model_stream = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      last_cyc = cyc;

      for (int i = 0; i < 1000 && frames_done < 1; i++) @(negedge clk);
      check_eq("post_rst_frame", frames_done >= 1, 1);
      send_cmd(8'h42, 16'hBEEF);
      checkpoint("post_rst_cmd");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
